// File: rtl/sc_fifo_ram.sv
// Simple dual-port storage for sc_fifo: synchronous write port and
// a registered, read-enabled read port that resets to zero.
module sc_fifo_ram #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [ADDRESS_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    input  logic                     re_i,
    input  logic [ADDRESS_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]    rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDRESS_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sc_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Define SC_FIFO_COUNT_EN to add the occupancy output `count`.
module sc_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     wr_en,
    output logic                     full,
    output logic [DATA_WIDTH-1:0]    data_out,
    input  logic                     rd_en,
`ifdef SC_FIFO_COUNT_EN
    output logic [ADDRESS_WIDTH:0]   count,
`endif
    output logic                     empty
);

    localparam int PTR_W = ADDRESS_WIDTH + 1;

    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] wptr_d;
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W-1:0] rptr_d;
    logic             wr_ok;
    logic             rd_ok;

    // Extra MSB distinguishes full from empty when low bits match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[ADDRESS_WIDTH-1:0] == rptr_q[ADDRESS_WIDTH-1:0])
                && (wptr_q[ADDRESS_WIDTH] != rptr_q[ADDRESS_WIDTH]);

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

`ifdef SC_FIFO_COUNT_EN
    assign count = wptr_q - rptr_q;
`endif

    sc_fifo_ram #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_ok),
        .waddr_i (wptr_q[ADDRESS_WIDTH-1:0]),
        .wdata_i (data_in),
        .re_i    (rd_ok),
        .raddr_i (rptr_q[ADDRESS_WIDTH-1:0]),
        .rdata_o (data_out)
    );

endmodule

// File: tb/tb_sc_fifo.sv
// Directed bench for sc_fifo: a 9x16 instance for the directed
// cases and a 8x4 instance for wrap-around streaming.
module tb_sc_fifo;

    logic       clk = 1'b0;
    logic       rst;

    logic [8:0] a_din;
    logic       a_wr;
    logic       a_rd;
    logic       a_full;
    logic       a_empty;
    logic [8:0] a_dout;

    logic [7:0] b_din;
    logic       b_wr;
    logic       b_rd;
    logic       b_full;
    logic       b_empty;
    logic [7:0] b_dout;

`ifdef SC_FIFO_COUNT_EN
    logic [4:0] a_count;
    logic [2:0] b_count;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sc_fifo #(
        .DATA_WIDTH    (9),
        .ADDRESS_WIDTH (4)
    ) u_a (
        .clk      (clk),
        .rst      (rst),
        .data_in  (a_din),
        .wr_en    (a_wr),
        .full     (a_full),
        .data_out (a_dout),
        .rd_en    (a_rd),
`ifdef SC_FIFO_COUNT_EN
        .count    (a_count),
`endif
        .empty    (a_empty)
    );

    sc_fifo #(
        .DATA_WIDTH    (8),
        .ADDRESS_WIDTH (2)
    ) u_b (
        .clk      (clk),
        .rst      (rst),
        .data_in  (b_din),
        .wr_en    (b_wr),
        .full     (b_full),
        .data_out (b_dout),
        .rd_en    (b_rd),
`ifdef SC_FIFO_COUNT_EN
        .count    (b_count),
`endif
        .empty    (b_empty)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int q[$];
        int wi;
        int ri;
        int ex;
        bit acc_w;
        bit acc_r;

        rst   = 1'b0;
        a_din = '0;
        a_wr  = 1'b0;
        a_rd  = 1'b0;
        b_din = '0;
        b_wr  = 1'b0;
        b_rd  = 1'b0;
        #12;
        chk("rst_empty", a_empty, 1);
        chk("rst_full", a_full, 0);
        chk("rst_dout", a_dout, 0);
        chk("rst_b_empty", b_empty, 1);
        rst = 1'b1;
        tick();

        // Write three 9-bit words, then read them back.
        a_wr = 1'b1;
        a_din = 9'h1A5;
        tick();
        chk("wr1_empty", a_empty, 0);
        a_din = 9'h0FF;
        tick();
        a_din = 9'h100;
        tick();
        a_wr = 1'b0;
        a_rd = 1'b1;
        tick();
        chk("rd1", a_dout, 9'h1A5);
        tick();
        chk("rd2", a_dout, 9'h0FF);
        tick();
        chk("rd3", a_dout, 9'h100);
        chk("rd3_empty", a_empty, 1);

        // Underflow: data_out must hold 0x33.
        a_rd = 1'b0;
        a_wr = 1'b1;
        a_din = 9'h033;
        tick();
        a_wr = 1'b0;
        a_rd = 1'b1;
        tick();
        chk("uf_load", a_dout, 9'h033);
        tick();
        chk("uf_hold", a_dout, 9'h033);
        chk("uf_empty", a_empty, 1);
        a_rd = 1'b0;
        a_wr = 1'b1;
        a_din = 9'h044;
        tick();
        chk("uf_wr_empty", a_empty, 0);
        a_wr = 1'b0;
        a_rd = 1'b1;
        tick();
        chk("uf_rd", a_dout, 9'h044);
        chk("uf_rd_empty", a_empty, 1);
        a_rd = 1'b0;

        // Fill 16 entries; the 17th write must be dropped.
        a_wr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_din = 9'(i);
            tick();
            if (i == 14) chk("fill15_full", a_full, 0);
        end
        chk("fill_full", a_full, 1);
`ifdef SC_FIFO_COUNT_EN
        chk("fill_count", a_count, 16);
`endif
        a_din = 9'h0AA;
        tick();
        chk("ovf_full", a_full, 1);

        // Both asserted while full: only the read proceeds.
        a_din = 9'h0BB;
        a_rd = 1'b1;
        tick();
        chk("full_rw_dout", a_dout, 0);
        chk("full_rw_full", a_full, 0);
        a_wr = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("drain", a_dout, 32'(i));
        end
        chk("drain_empty", a_empty, 1);

        // Both asserted while empty: only the write proceeds.
        a_wr = 1'b1;
        a_din = 9'h055;
        tick();
        chk("empty_rw_dout", a_dout, 9'h00F);
        chk("empty_rw_empty", a_empty, 0);
        a_rd = 1'b0;
        a_din = 9'h056;
        tick();
        a_din = 9'h057;
        tick();
`ifdef SC_FIFO_COUNT_EN
        chk("occ3_count", a_count, 3);
`endif

        // Occupancy 3 with concurrent read and write for 10 cycles.
        a_rd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_din = 9'(9'h060 + i);
            tick();
            if (i < 3) chk("conc", a_dout, 32'(9'h055 + i));
            else       chk("conc", a_dout, 32'(9'h060 + i - 3));
        end
        chk("conc_empty", a_empty, 0);
        chk("conc_full", a_full, 0);
`ifdef SC_FIFO_COUNT_EN
        chk("conc_count", a_count, 3);
`endif
        a_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("conc_drain", a_dout, 32'(9'h067 + i));
        end
        chk("conc_drain_empty", a_empty, 1);
        a_rd = 1'b0;

        // Reset mid-stream with 5 entries stored.
        a_wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_din = 9'(9'h0C0 + i);
            tick();
        end
        a_wr = 1'b0;
        rst = 1'b0;
        #1;
        chk("mrst_empty", a_empty, 1);
        chk("mrst_full", a_full, 0);
        chk("mrst_dout", a_dout, 0);
`ifdef SC_FIFO_COUNT_EN
        chk("mrst_count", a_count, 0);
`endif
        #3;
        rst = 1'b1;
        tick();
        a_rd = 1'b1;
        tick();
        chk("mrst_rd_empty", a_empty, 1);
        chk("mrst_rd_dout", a_dout, 0);
        a_rd = 1'b0;
        a_wr = 1'b1;
        a_din = 9'h077;
        tick();
        a_wr = 1'b0;
        a_rd = 1'b1;
        tick();
        chk("mrst_first", a_dout, 9'h077);
        a_rd = 1'b0;

        // Stream 50 words through the 4-deep instance.
        wi = 0;
        ri = 0;
        for (int c = 0; c < 2000 && ri < 50; c++) begin
            b_wr = ($urandom_range(0, 1) == 1) && (wi < 50);
            b_rd = $urandom_range(0, 3) < (((c / 8) % 2 == 1) ? 3 : 1);
            b_din = 8'(wi);
            acc_w = b_wr && (q.size() < 4);
            acc_r = b_rd && (q.size() > 0);
            ex = 0;
            if (acc_r) ex = q.pop_front();
            if (acc_w) begin
                q.push_back(wi);
                wi++;
            end
            tick();
            if (acc_r) begin
                chk("wrap_data", b_dout, 32'(ex));
                ri++;
            end
            chk("wrap_empty", b_empty, 32'(q.size() == 0));
            chk("wrap_full", b_full, 32'(q.size() == 4));
`ifdef SC_FIFO_COUNT_EN
            chk("wrap_count", b_count, 32'(q.size()));
`endif
        end
        b_wr = 1'b0;
        b_rd = 1'b0;
        chk("wrap_done", ri, 50);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
